// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface mc_control_if;
  logic [5:0] op;
  logic       zero;
  logic       memrdy;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic [3:0] irwrite;
  logic       pcen;
  logic [1:0] pcsource;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, memrdy,
    output memread, memwrite, iord, irwrite, pcen, pcsource, alusrca,
           alusrcb, aluop, regwrite, regdst, memtoreg, illegal, state
  );

  modport slave (
    output op, zero, memrdy,
    input  memread, memwrite, iord, irwrite, pcen, pcsource, alusrca,
           alusrcb, aluop, regwrite, regdst, memtoreg, illegal, state
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle control FSM for the 8-bit MIPS datapath
// Optional ADDI support: define MC_CONTROL_ADDI_EN.
module mc_control #(
  parameter int FETCH_BYTES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,  S_FETCH2  = 4'd1,  S_FETCH3  = 4'd2,  S_FETCH4 = 4'd3,
    S_DECODE  = 4'd4,  S_MEMADR  = 4'd5,  S_LBRD    = 4'd6,  S_LBWR   = 4'd7,
    S_SBWR    = 4'd8,  S_RTYPEEX = 4'd9,  S_RTYPEWR = 4'd10, S_BEQEX  = 4'd11,
    S_JEX     = 4'd12, S_ADDIEX  = 4'd13, S_ADDIWR  = 4'd14, S_BAD    = 4'd15
  } state_t;

  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam state_t S_LAST_FETCH = state_t'(4'(FETCH_BYTES - 1));

  // Moore part of every output, registered alongside the state.
  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       iord;
    logic [3:0] irw;
    logic       fetch;
    logic       beq;
    logic       jex;
    logic       dec;
    logic       bad;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic       rd;
    logic       m2r;
  } moore_t;

  function automatic moore_t moore(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        m.mr    = 1'b1;
        m.asb   = 2'b01;
        m.fetch = 1'b1;
        m.irw   = 4'b0001 << 2'(s);
      end
      S_DECODE: begin
        m.asb = 2'b11;
        m.dec = 1'b1;
      end
      S_MEMADR: begin
        m.asa = 1'b1;
        m.asb = 2'b10;
      end
      S_LBRD: begin
        m.mr   = 1'b1;
        m.iord = 1'b1;
      end
      S_LBWR: begin
        m.rw  = 1'b1;
        m.m2r = 1'b1;
      end
      S_SBWR: begin
        m.mw   = 1'b1;
        m.iord = 1'b1;
      end
      S_RTYPEEX: begin
        m.asa = 1'b1;
        m.aop = 2'b10;
      end
      S_RTYPEWR: begin
        m.rw = 1'b1;
        m.rd = 1'b1;
      end
      S_BEQEX: begin
        m.asa = 1'b1;
        m.aop = 2'b01;
        m.pcs = 2'b01;
        m.beq = 1'b1;
      end
      S_JEX: begin
        m.pcs = 2'b10;
        m.jex = 1'b1;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: begin
        m.asa = 1'b1;
        m.asb = 2'b10;
      end
      S_ADDIWR: m.rw = 1'b1;
`endif
      default: m.bad = 1'b1;
    endcase
    return m;
  endfunction

  state_t state_q, state_d;
  moore_t out_q, out_d;
  logic   op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LB, OP_SB, OP_R, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MC_CONTROL_ADDI_EN
      OP_ADDI: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4:
        if (bus.memrdy)
          state_d = (state_q == S_LAST_FETCH) ? S_DECODE : state_t'(state_q + 4'd1);
      S_DECODE: begin
        case (bus.op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SB) ? S_SBWR : S_LBRD;
      S_LBRD:    if (bus.memrdy) state_d = S_LBWR;
      S_SBWR:    if (bus.memrdy) state_d = S_FETCH1;
      S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWR;
`endif
      default:   state_d = S_FETCH1;
    endcase
    out_d = moore(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH1;
      out_q   <= moore(S_FETCH1);
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Strobes are masked by reset so nothing fires while the unit is held.
  assign bus.memread  = reset_n & out_q.mr;
  assign bus.memwrite = reset_n & out_q.mw;
  assign bus.irwrite  = (reset_n & bus.memrdy) ? out_q.irw : 4'b0000;
  assign bus.pcen     = reset_n & ((out_q.fetch & bus.memrdy) | (out_q.beq & bus.zero) | out_q.jex);
  assign bus.regwrite = reset_n & out_q.rw;
  assign bus.illegal  = reset_n & (out_q.bad | (out_q.dec & ~op_legal));
  assign bus.iord     = out_q.iord;
  assign bus.pcsource = out_q.pcs;
  assign bus.alusrca  = out_q.asa;
  assign bus.alusrcb  = out_q.asb;
  assign bus.aluop    = out_q.aop;
  assign bus.regdst   = out_q.rd;
  assign bus.memtoreg = out_q.m2r;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control against an instruction-level plan model
module tb_mc_control;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mc_control_if bus ();
  mc_control #(.FETCH_BYTES(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // strb = {memread, memwrite, irwrite[3:0], pcen, regwrite, illegal}
  typedef struct {
    logic       rdy;
    logic [5:0] op;
    logic       z;
    logic [8:0] strb;
    logic       iord_v;
    logic       iord;
    logic       sel_v;
    logic [1:0] sel;
    logic       pcs_v;
    logic [1:0] pcs;
    logic       alu_v;
    logic [1:0] alu;
    logic       st_v;
    logic [3:0] st;
  } cyc_t;

  cyc_t plan[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c.rdy = 1'($urandom);
    c.op = 6'($urandom);
    c.z = 1'($urandom);
    c.strb = '0;
    c.iord_v = 0; c.iord = 0;
    c.sel_v = 0;  c.sel = 0;
    c.pcs_v = 0;  c.pcs = 0;
    c.alu_v = 0;  c.alu = 0;
    c.st_v = 0;   c.st = 0;
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from the opcode class and wait counts.
  task automatic add_instr(input logic [5:0] opc, input logic zv, input logic [15:0] fw, input int mw);
    cyc_t c;
    bit addi_en = 0;
    bit is_lb, is_sb, is_r, is_beq, is_j, is_addi, legal;
`ifdef MC_CONTROL_ADDI_EN
    addi_en = 1;
`endif
    is_lb = (opc == 6'b100000);
    is_sb = (opc == 6'b101000);
    is_r = (opc == 6'b000000);
    is_beq = (opc == 6'b000100);
    is_j = (opc == 6'b000010);
    is_addi = (opc == 6'b001000) && addi_en;
    legal = is_lb | is_sb | is_r | is_beq | is_j | is_addi;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(fw[4*k +: 4]); i++) begin
        c = blank(); c.rdy = 0; c.strb = 9'h100; c.iord_v = 1; c.iord = 0;
        if (k == 0 && i == 0) begin c.st_v = 1; c.st = 0; end
        plan.push_back(c);
      end
      c = blank(); c.rdy = 1;
      c.strb = {1'b1, 1'b0, 4'(4'b0001 << k), 1'b1, 1'b0, 1'b0};
      c.iord_v = 1; c.iord = 0; c.pcs_v = 1; c.pcs = 2'b00;
      if (k == 0 && fw[3:0] == 0) begin c.st_v = 1; c.st = 0; end
      plan.push_back(c);
    end
    c = blank(); c.op = opc; c.strb = {8'h00, !legal}; c.st_v = 1; c.st = 4'd4;
    plan.push_back(c);
    if (is_lb || is_sb) begin
      c = blank(); c.op = opc; plan.push_back(c);
      for (int i = 0; i <= mw; i++) begin
        c = blank(); c.rdy = (i == mw);
        c.strb = is_lb ? 9'h100 : 9'h080; c.iord_v = 1; c.iord = 1;
        plan.push_back(c);
      end
      if (is_lb) begin
        c = blank(); c.strb = 9'h002; c.sel_v = 1; c.sel = 2'b01; plan.push_back(c);
      end
    end else if (is_r) begin
      c = blank(); c.alu_v = 1; c.alu = 2'b10; plan.push_back(c);
      c = blank(); c.strb = 9'h002; c.sel_v = 1; c.sel = 2'b10; plan.push_back(c);
    end else if (is_beq) begin
      c = blank(); c.z = zv; c.strb = zv ? 9'h004 : 9'h000;
      c.pcs_v = 1; c.pcs = 2'b01; c.alu_v = 1; c.alu = 2'b01; plan.push_back(c);
    end else if (is_j) begin
      c = blank(); c.strb = 9'h004; c.pcs_v = 1; c.pcs = 2'b10; plan.push_back(c);
    end else if (is_addi) begin
      c = blank(); c.alu_v = 1; c.alu = 2'b00; plan.push_back(c);
      c = blank(); c.strb = 9'h002; c.sel_v = 1; c.sel = 2'b00; plan.push_back(c);
    end
  endtask

  // Entered and left at posedge+1; n < 0 runs the whole plan.
  task automatic run_plan(input int n);
    cyc_t c;
    int done = 0;
    while (plan.size() > 0 && (n < 0 || done < n)) begin
      c = plan.pop_front();
      bus.memrdy = c.rdy; bus.op = c.op; bus.zero = c.z;
      @(negedge clk);
      chk("strobes", {7'd0, bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.illegal},
          {7'd0, c.strb});
      if (c.iord_v) chk("iord", {15'd0, bus.iord}, {15'd0, c.iord});
      if (c.sel_v) chk("regdst_memtoreg", {14'd0, bus.regdst, bus.memtoreg}, {14'd0, c.sel});
      if (c.pcs_v) chk("pcsource", {14'd0, bus.pcsource}, {14'd0, c.pcs});
      if (c.alu_v) chk("aluop", {14'd0, bus.aluop}, {14'd0, c.alu});
      if (c.st_v) chk("state", {12'd0, bus.state}, {12'd0, c.st});
      @(posedge clk); #1;
      done++;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    int k;
    ops = '{6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000};
    k = $urandom_range(0, 7);
    return (k < 6) ? ops[k] : 6'($urandom);
  endfunction

  initial begin
    bus.memrdy = 1'b1; bus.op = 6'd0; bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_state", {12'd0, bus.state}, 16'd0);
      chk("reset_strobes", {10'd0, bus.memread, bus.memwrite, bus.irwrite != 4'd0, bus.pcen,
          bus.regwrite, bus.illegal}, 16'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    add_instr(6'b000000, 1'b0, 16'h0000, 0);   // R-type, no waits (first cycle after reset)
    add_instr(6'b100000, 1'b0, 16'h0000, 3);   // LB with 3 wait cycles in LBRD
    add_instr(6'b000100, 1'b1, 16'h0000, 0);   // BEQ taken
    add_instr(6'b000100, 1'b0, 16'h0000, 0);   // BEQ not taken
    add_instr(6'b111111, 1'b0, 16'h0000, 0);   // illegal
    add_instr(6'b001000, 1'b0, 16'h0000, 0);   // ADDI (legal only with the macro)
    add_instr(6'b101000, 1'b0, 16'h1201, 2);   // SB with fetch and write waits
    add_instr(6'b000010, 1'b0, 16'h0010, 0);   // J
    run_plan(-1);

    // Reset while LB waits in LBRD: no write may follow.
    add_instr(6'b100000, 1'b0, 16'h0000, 5);
    run_plan(7);
    plan.delete();
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_strobes", {10'd0, bus.memread, bus.memwrite, bus.irwrite != 4'd0, bus.pcen,
        bus.regwrite, bus.illegal}, 16'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midreset_state", {12'd0, bus.state}, 16'd0);
    add_instr(6'b000000, 1'b0, 16'h0000, 0);
    run_plan(-1);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] fw;
      fw = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 1) fw[4*k +: 4] = 4'($urandom_range(1, 2));
      add_instr(pick_op(), 1'($urandom), fw, $urandom_range(0, 3));
      run_plan(-1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
